// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one pipelined unsigned multiplier among
// NREQ requesters and returns each product tagged with its requester id.
module mult_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [2*N-1:0]      resp_p,
    output logic                busy
);

    // Handshake: a beat moves when valid && ready on the same rising edge;
    // valid and payload are held by the sender until that edge, and ready
    // never depends on payload.

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt;
    logic            found;
    logic            advance;
    logic            xfer;
    logic [NREQ-1:0] rot;
    int              idx;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;

    // Stage 0 holds operands; stages 1..LAT hold products; stage LAT is the output.
    logic [N-1:0]     s0_a;
    logic [N-1:0]     s0_b;
    logic [LAT:0]     v_q;
    logic [IDW-1:0]   id_q [0:LAT];
    logic [2*N-1:0]   p_q  [1:LAT];

    assign advance = !v_q[LAT] || resp_ready;

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        rot   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            rot = req_valid >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    assign xfer      = found && advance && !rst;
    assign req_ready = xfer ? (NREQ'(1) << gnt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            ptr  <= '0;
            s0_a <= '0;
            s0_b <= '0;
            for (int k = 0; k <= LAT; k++) id_q[k] <= '0;
            for (int k = 1; k <= LAT; k++) p_q[k]  <= '0;
        end else if (advance) begin
            v_q     <= {v_q[LAT-1:0], xfer};
            s0_a    <= sel_a;
            s0_b    <= sel_b;
            id_q[0] <= gnt;
            for (int k = 1; k <= LAT; k++) id_q[k] <= id_q[k-1];
            p_q[1]  <= (2*N)'(s0_a) * (2*N)'(s0_b);
            for (int k = 2; k <= LAT; k++) p_q[k] <= p_q[k-1];
            if (xfer) begin
                if (gnt == IDW'(NREQ-1)) ptr <= '0;
                else                     ptr <= gnt + 1'b1;
            end
        end
    end

    assign resp_valid = v_q[LAT];
    assign resp_id    = id_q[LAT];
    assign resp_p     = p_q[LAT];
    assign busy       = |v_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: reset, latency, round-robin order,
// back-pressure, operand extremes, pointer wrap and mid-operation reset.
module tb_mult_arbiter;

    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [2*N-1:0]      resp_p;
    logic                busy;

    int n_cmp;
    int n_fail;
    int n_got;

    logic [IDW-1:0] exp_id_q[$];
    logic [2*N-1:0] exp_p_q[$];
    logic [NREQ-1:0] exp_g;
    logic [IDW-1:0]  e_id;
    logic [2*N-1:0]  e_p;

    mult_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        exp_id_q.delete();
        exp_p_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;
        #12;
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
        n_cmp++; if (resp_p !== 32'd0) begin n_fail++; $display("FAIL reset_resp_p got=%h exp=0", resp_p); end
    endtask

    task automatic test_single();
        do_reset();
        set_op(2, 16'd3, 16'd5);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_e0 busy=%b valid=%b exp busy=1 valid=0", busy, resp_valid); end
        tick();
        n_cmp++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_e1 busy=%b valid=%b exp busy=1 valid=0", busy, resp_valid); end
        tick();
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_p !== 32'd15 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_resp valid=%b id=%0d p=%0d busy=%b exp 1/2/15/1", resp_valid, resp_id, resp_p, busy);
        end
        tick();
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain valid=%b busy=%b exp 0/0", resp_valid, busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'd10);
        req_valid = 4'hF;
        n_got = 0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) begin
                req_valid = '0;
                #1;
            end
            if (c < 8) begin
                exp_g = 4'b0001 << (c % 4);
                n_cmp++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_g); end
                exp_id_q.push_back(IDW'(c % 4));
                exp_p_q.push_back(32'((c % 4 + 1) * 10));
            end
            tick();
            if (resp_valid) begin
                n_got++;
                if (exp_id_q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL rr_extra id=%0d p=%0d exp none", resp_id, resp_p);
                end else begin
                    e_id = exp_id_q.pop_front();
                    e_p  = exp_p_q.pop_front();
                    n_cmp++; if (resp_id !== e_id || resp_p !== e_p) begin n_fail++; $display("FAIL rr_resp got=(%0d,%0d) exp=(%0d,%0d)", resp_id, resp_p, e_id, e_p); end
                end
            end
        end
        n_cmp++; if (n_got != 8) begin n_fail++; $display("FAIL rr_count got=%0d exp=8", n_got); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'd3);
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_g = 4'b0001 << k;
            n_cmp++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL bp_grant k=%0d got=%b exp=%b", k, req_ready, exp_g); end
            tick();
        end
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_p !== 32'd3) begin n_fail++; $display("FAIL bp_first valid=%b id=%0d p=%0d exp 1/0/3", resp_valid, resp_id, resp_p); end
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_ready_stall got=%b exp=0000", req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_p !== 32'd3 || req_ready !== 4'h0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold k=%0d valid=%b id=%0d p=%0d rdy=%b busy=%b exp 1/0/3/0000/1", k, resp_valid, resp_id, resp_p, req_ready, busy);
            end
        end
        resp_ready = 1'b1;
        req_valid  = '0;
        exp_id_q.push_back(2'd1); exp_p_q.push_back(32'd6);
        exp_id_q.push_back(2'd2); exp_p_q.push_back(32'd9);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (resp_valid) begin
                if (exp_id_q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL bp_extra id=%0d p=%0d exp none", resp_id, resp_p);
                end else begin
                    e_id = exp_id_q.pop_front();
                    e_p  = exp_p_q.pop_front();
                    n_cmp++; if (resp_id !== e_id || resp_p !== e_p) begin n_fail++; $display("FAIL bp_resp got=(%0d,%0d) exp=(%0d,%0d)", resp_id, resp_p, e_id, e_p); end
                end
            end
        end
        n_cmp++; if (exp_id_q.size() != 0) begin n_fail++; $display("FAIL bp_lost remaining=%0d exp=0", exp_id_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy got=%b exp=0", busy); end
    endtask

    task automatic test_width();
        do_reset();
        set_op(0, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wid_grant0 got=%b exp=0001", req_ready); end
        tick();
        set_op(0, 16'h0000, 16'h1234);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wid_grant1 got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_cmp++; if (resp_valid !== 1'b1 || resp_p !== 32'hFFFE0001) begin n_fail++; $display("FAIL wid_ones valid=%b p=%h exp 1/fffe0001", resp_valid, resp_p); end
        tick();
        n_cmp++; if (resp_valid !== 1'b1 || resp_p !== 32'h0) begin n_fail++; $display("FAIL wid_zero valid=%b p=%h exp 1/00000000", resp_valid, resp_p); end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        set_op(1, 16'd7, 16'd7);
        set_op(3, 16'd9, 16'd9);
        req_valid = 4'b1010;
        n_got = 0;
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) begin
                req_valid = '0;
                #1;
            end
            if (c < 4) begin
                exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
                n_cmp++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL sw_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_g); end
                exp_id_q.push_back((c % 2 == 0) ? 2'd1 : 2'd3);
                exp_p_q.push_back((c % 2 == 0) ? 32'd49 : 32'd81);
            end
            tick();
            if (resp_valid) begin
                n_got++;
                if (exp_id_q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL sw_extra id=%0d p=%0d exp none", resp_id, resp_p);
                end else begin
                    e_id = exp_id_q.pop_front();
                    e_p  = exp_p_q.pop_front();
                    n_cmp++; if (resp_id !== e_id || resp_p !== e_p) begin n_fail++; $display("FAIL sw_resp got=(%0d,%0d) exp=(%0d,%0d)", resp_id, resp_p, e_id, e_p); end
                end
            end
        end
        n_cmp++; if (n_got != 4) begin n_fail++; $display("FAIL sw_count got=%0d exp=4", n_got); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_op(1, 16'd4, 16'd4);
        set_op(2, 16'd5, 16'd5);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        n_cmp++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_inflight busy=%b valid=%b exp 1/0", busy, resp_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
            n_fail++; $display("FAIL mr_async valid=%b busy=%b rdy=%b exp 0/0/0000", resp_valid, busy, req_ready);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mr_stale cyc=%0d valid=%b busy=%b exp 0/0", c, resp_valid, busy); end
        end
        set_op(3, 16'd2, 16'd11);
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mr_grant got=%b exp=1000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_early valid=%b exp=0", resp_valid); end
        tick();
        n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_p !== 32'd22) begin n_fail++; $display("FAIL mr_resp valid=%b id=%0d p=%0d exp 1/3/22", resp_valid, resp_id, resp_p); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_width();
        test_skip_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
